// File: rtl/log2_rr_sched_pkg.sv
// Purpose: shared defaults, FSM state encoding and constant helpers for the log2 scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package log2_pkg;

  localparam int BIT_IN_DEF  = 12;
  localparam int BIT_OUT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Ceiling log2 usable in parameter expressions
  function automatic int clog2(input int val);
    int r;
    r = 0;
    while ((1 << r) < val) r++;
    return r;
  endfunction

endpackage

// File: rtl/log2_rr_sched_if.sv
// Purpose: request/response bundle between requesting datapath blocks and the log2 scheduler.
// Latency: n/a (wiring only).
// Backpressure: request side valid/ready per requester, response side valid/ready per requester.
interface log2_rr_sched_if
  import log2_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BIT_IN  = BIT_IN_DEF,
  parameter int BIT_OUT = BIT_OUT_DEF
);

  logic [NREQ-1:0]        Req_Valid;
  logic [NREQ*BIT_IN-1:0] Req_Data;
  logic [NREQ-1:0]        Req_Ready;
  logic [NREQ-1:0]        Rsp_Valid;
  logic [NREQ-1:0]        Rsp_Ready;
  logic [BIT_OUT-1:0]     Rsp_Data;
  logic                   Rsp_Zero;

  // Requester side
  modport master (
    output Req_Valid, Req_Data, Rsp_Ready,
    input  Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Zero
  );

  // Scheduler side
  modport slave (
    input  Req_Valid, Req_Data, Rsp_Ready,
    output Req_Ready, Rsp_Valid, Rsp_Data, Rsp_Zero
  );

endinterface

// File: rtl/log2_rr_sched_core.sv
// Purpose: floor-log2 of one latched operand via priority encoder, with zero flag.
// Latency: LAT register stages after the operand register; final stage loads on resLoad.
// Backpressure: none; result register holds its value until the next resLoad.
module log2_core
  import log2_pkg::*;
#(
  parameter int BIT_IN  = BIT_IN_DEF,
  parameter int BIT_OUT = BIT_OUT_DEF,
  parameter int LAT     = 1
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               opLoad,
  input  logic [BIT_IN-1:0]  opData,
  input  logic               resLoad,
  output logic [BIT_OUT-1:0] resData,
  output logic               resZero
);

  if (BIT_OUT != clog2(BIT_IN)) begin : gBadOut
    $error("log2_core: BIT_OUT must equal clog2(BIT_IN)");
  end
  if (LAT < 1 || LAT > 3) begin : gBadLat
    $error("log2_core: LAT must be 1..3");
  end

  logic [BIT_IN-1:0]  opReg;
  logic [BIT_OUT-1:0] encData;
  logic               encZero;
  logic [BIT_OUT-1:0] tapData;
  logic               tapZero;

  // Operand register, captured on the accepting handshake
  always_ff @(posedge Clk) begin
    if (Rst) opReg <= '0;
    else if (opLoad) opReg <= opData;
  end

  // Priority encoder: highest set bit wins; zero operand yields 0 with flag
  always_comb begin
    encData = '0;
    for (int i = 0; i < BIT_IN; i++) begin
      if (opReg[i]) encData = BIT_OUT'(i);
    end
    encZero = ~|opReg;
  end

  if (LAT == 1) begin : gNoPipe
    assign tapData = encData;
    assign tapZero = encZero;
  end else begin : gPipe
    logic [BIT_OUT-1:0] stgData [1:LAT-1];
    logic               stgZero [1:LAT-1];
    // Free-running intermediate stages; operand is stable while they fill
    always_ff @(posedge Clk) begin
      if (Rst) begin
        for (int j = 1; j < LAT; j++) begin
          stgData[j] <= '0;
          stgZero[j] <= 1'b0;
        end
      end else begin
        stgData[1] <= encData;
        stgZero[1] <= encZero;
        for (int j = 2; j < LAT; j++) begin
          stgData[j] <= stgData[j-1];
          stgZero[j] <= stgZero[j-1];
        end
      end
    end
    assign tapData = stgData[LAT-1];
    assign tapZero = stgZero[LAT-1];
  end

  // Result register: loads once per operation, otherwise holds the last result
  always_ff @(posedge Clk) begin
    if (Rst) begin
      resData <= '0;
      resZero <= 1'b0;
    end else if (resLoad) begin
      resData <= tapData;
      resZero <= tapZero;
    end
  end

endmodule

// File: rtl/log2_rr_sched.sv
// Purpose: round-robin scheduler sharing one floor-log2 core among NREQ requesters.
// Latency: handshake in cycle t -> Rsp_Valid in cycle t+1+LAT; one operation in flight.
// Backpressure: Req_Ready only in IDLE; response held until the owner's Rsp_Ready.
module log2_rr_sched
  import log2_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BIT_IN  = BIT_IN_DEF,
  parameter int BIT_OUT = BIT_OUT_DEF,
  parameter int LAT     = 1
) (
  input  logic           Clk,
  input  logic           Rst,
  log2_rr_sched_if.slave bus,
  output logic           Busy
);

  if (NREQ < 2 || NREQ > 8) begin : gBadReq
    $error("log2_rr_sched: NREQ must be 2..8");
  end

  localparam int IDW = clog2(NREQ);
  localparam int CW  = 2;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  owner;
  logic [IDW-1:0]  rrPtr;
  logic [IDW-1:0]  winId;
  logic            anyReq;
  logic [NREQ-1:0] reqReady;
  logic [NREQ-1:0] rspValidQ;
  logic            busyQ;
  logic            accept;
  logic            resLoad;
  logic [BIT_IN-1:0] opSel;

  // Round-robin search starting at rrPtr, ascending with wrap
  always_comb begin
    int idx;
    idx    = 0;
    winId  = '0;
    anyReq = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rrPtr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!anyReq && bus.Req_Valid[idx]) begin
        anyReq = 1'b1;
        winId  = IDW'(idx);
      end
    end
  end

  // Grant is combinational so the winner's handshake completes in the IDLE cycle
  always_comb begin
    reqReady = '0;
    if (state == IDLE && anyReq) reqReady[winId] = 1'b1;
  end

  assign accept  = (state == IDLE) && anyReq;
  assign resLoad = (state == CALC) && (cnt == CW'(1));
  assign opSel   = bus.Req_Data[int'(winId)*BIT_IN +: BIT_IN];

  // Scheduler FSM: owner tracking, latency count, response valid and pointer update
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      owner     <= '0;
      rrPtr     <= '0;
      rspValidQ <= '0;
      busyQ     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            owner <= winId;
            cnt   <= CW'(LAT);
            state <= CALC;
            busyQ <= 1'b1;
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state     <= RESP;
            rspValidQ <= NREQ'(1) << owner;
          end
        end
        RESP: begin
          // Only the owner's ready counts; other requesters cannot retire this result
          if (bus.Rsp_Ready[owner]) begin
            rspValidQ <= '0;
            rrPtr     <= (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;
            state     <= IDLE;
            busyQ     <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rspValidQ <= '0;
          busyQ     <= 1'b0;
        end
      endcase
    end
  end

  log2_core #(
    .BIT_IN  (BIT_IN),
    .BIT_OUT (BIT_OUT),
    .LAT     (LAT)
  ) uCore (
    .Clk     (Clk),
    .Rst     (Rst),
    .opLoad  (accept),
    .opData  (opSel),
    .resLoad (resLoad),
    .resData (bus.Rsp_Data),
    .resZero (bus.Rsp_Zero)
  );

  assign bus.Req_Ready = reqReady;
  assign bus.Rsp_Valid = rspValidQ;
  assign Busy          = busyQ;

endmodule

// File: tb/tb_log2_rr_sched.sv
// Purpose: directed self-checking bench for log2_rr_sched (NREQ=4, 12-bit in, LAT=1).
// Latency: expects Rsp_Valid two cycles after the request handshake.
// Backpressure: exercises owner stall, non-owner ready and reset abort.
module tb_log2_rr_sched;

  logic Clk;
  logic Rst;
  logic Busy;

  int total;
  int bad;

  log2_rr_sched_if #(.NREQ(4), .BIT_IN(12), .BIT_OUT(4)) bus ();

  log2_rr_sched #(
    .NREQ    (4),
    .BIT_IN  (12),
    .BIT_OUT (4),
    .LAT     (1)
  ) dut (
    .Clk  (Clk),
    .Rst  (Rst),
    .bus  (bus),
    .Busy (Busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Requesters must hold Req_Valid until their handshake completes
  logic [3:0] pendV;
  always @(posedge Clk) begin
    assert (Rst || ((pendV & ~bus.Req_Valid) == 4'b0))
      else $error("requester dropped Req_Valid before accept");
    pendV <= Rst ? 4'b0 : (bus.Req_Valid & ~bus.Req_Ready);
  end

  task automatic chkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic setData(input int idx, input logic [11:0] d);
    bus.Req_Data[idx*12 +: 12] = d;
  endtask

  function automatic int ohIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic rstPulse();
    @(negedge Clk);
    Rst = 1'b1;
    bus.Req_Valid = '0;
    bus.Rsp_Ready = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
  endtask

  // One complete isolated operation with immediate accept
  task automatic doOp(input string tag, input int idx, input logic [11:0] d,
                      input logic [3:0] expD, input logic expZ);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    @(negedge Clk);
    bus.Req_Valid = oh;
    setData(idx, d);
    #1;
    chkVal({tag, ".grant"}, bus.Req_Ready, oh);
    @(negedge Clk);
    bus.Req_Valid = '0;
    #1;
    chkVal({tag, ".calcVld"}, bus.Rsp_Valid, 0);
    chkVal({tag, ".calcBusy"}, Busy, 1);
    @(negedge Clk);
    #1;
    chkVal({tag, ".rspVld"}, bus.Rsp_Valid, oh);
    chkVal({tag, ".rspDat"}, bus.Rsp_Data, expD);
    chkVal({tag, ".rspZero"}, bus.Rsp_Zero, expZ);
    bus.Rsp_Ready = oh;
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    #1;
    chkVal({tag, ".doneVld"}, bus.Rsp_Valid, 0);
    chkVal({tag, ".doneBusy"}, Busy, 0);
  endtask

  int nG;
  int gIdx [5];
  int gCyc [5];
  int expG [5];

  initial begin
    total = 0;
    bad   = 0;
    expG  = '{0, 1, 2, 3, 0};
    Rst   = 1'b1;
    bus.Req_Valid = '0;
    bus.Req_Data  = '0;
    bus.Rsp_Ready = '0;

    // Reset state
    repeat (3) @(negedge Clk);
    #1;
    chkVal("rst.reqRdy", bus.Req_Ready, 0);
    chkVal("rst.rspVld", bus.Rsp_Valid, 0);
    chkVal("rst.rspDat", bus.Rsp_Data, 0);
    chkVal("rst.rspZero", bus.Rsp_Zero, 0);
    chkVal("rst.busy", Busy, 0);
    Rst = 1'b0;

    // Single request
    doOp("t1", 2, 12'd1000, 4'd9, 1'b0);

    // Boundary operands through requester 0
    doOp("t2.z", 0, 12'd0, 4'd0, 1'b1);
    doOp("t2.1", 0, 12'd1, 4'd0, 1'b0);
    doOp("t2.2047", 0, 12'd2047, 4'd10, 1'b0);
    doOp("t2.2048", 0, 12'd2048, 4'd11, 1'b0);
    doOp("t2.4095", 0, 12'd4095, 4'd11, 1'b0);

    // All requesting continuously from reset
    rstPulse();
    @(negedge Clk);
    bus.Req_Valid = 4'b1111;
    for (int i = 0; i < 4; i++) setData(i, 12'd1 << (i + 3));
    bus.Rsp_Ready = 4'b1111;
    nG = 0;
    for (int cyc = 0; cyc < 40 && nG < 5; cyc++) begin
      #1;
      if (bus.Req_Ready != 4'b0) begin
        chkVal("t3.onehot", $countones(bus.Req_Ready), 1);
        gIdx[nG] = ohIdx(bus.Req_Ready);
        gCyc[nG] = cyc;
        nG++;
      end
      if (bus.Rsp_Valid != 4'b0 && nG > 0) begin
        chkVal("t3.rspVld", bus.Rsp_Valid, 4'b0001 << gIdx[nG-1]);
        chkVal("t3.rspDat", bus.Rsp_Data, gIdx[nG-1] + 3);
      end
      if (nG < 5) @(negedge Clk);
    end
    chkVal("t3.count", nG, 5);
    for (int k = 0; k < nG; k++) chkVal("t3.order", gIdx[k], expG[k]);
    for (int k = 1; k < nG; k++) chkVal("t3.gap", gCyc[k] - gCyc[k-1], 3);

    // Owner backpressure, then non-owner ready, then accept and next grant
    rstPulse();
    @(negedge Clk);
    bus.Req_Valid = 4'b0010;
    setData(1, 12'd100);
    #1;
    chkVal("t4.grant", bus.Req_Ready, 4'b0010);
    @(negedge Clk);
    bus.Req_Valid = 4'b0100;
    setData(2, 12'd300);
    #1;
    chkVal("t4.calcRdy", bus.Req_Ready, 0);
    chkVal("t4.calcVld", bus.Rsp_Valid, 0);
    for (int h = 0; h < 5; h++) begin
      @(negedge Clk);
      if (h >= 2) bus.Rsp_Ready = 4'b1101;
      #1;
      chkVal("t4.holdVld", bus.Rsp_Valid, 4'b0010);
      chkVal("t4.holdDat", bus.Rsp_Data, 6);
      chkVal("t4.holdRdy", bus.Req_Ready, 0);
    end
    @(negedge Clk);
    bus.Rsp_Ready = 4'b0010;
    #1;
    chkVal("t5.stillVld", bus.Rsp_Valid, 4'b0010);
    chkVal("t5.busy", Busy, 1);
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    #1;
    chkVal("t4.accVld", bus.Rsp_Valid, 0);
    chkVal("t4.nextGrant", bus.Req_Ready, 4'b0100);
    chkVal("t4.datHeld", bus.Rsp_Data, 6);
    @(negedge Clk);
    bus.Req_Valid = '0;
    #1;
    chkVal("t4.calc2Vld", bus.Rsp_Valid, 0);
    @(negedge Clk);
    #1;
    chkVal("t4.rsp2Vld", bus.Rsp_Valid, 4'b0100);
    chkVal("t4.rsp2Dat", bus.Rsp_Data, 8);
    bus.Rsp_Ready = 4'b0100;
    @(negedge Clk);
    bus.Rsp_Ready = '0;

    // Reset during CALC aborts the operation and clears the pointer
    rstPulse();
    doOp("t6.pre", 1, 12'd5, 4'd2, 1'b0);
    @(negedge Clk);
    bus.Req_Valid = 4'b0100;
    setData(2, 12'd4095);
    #1;
    chkVal("t6.grant", bus.Req_Ready, 4'b0100);
    @(negedge Clk);
    bus.Req_Valid = '0;
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    #1;
    chkVal("t6.abortVld", bus.Rsp_Valid, 0);
    chkVal("t6.abortBusy", Busy, 0);
    repeat (2) begin
      @(negedge Clk);
      #1;
      chkVal("t6.quietVld", bus.Rsp_Valid, 0);
    end
    @(negedge Clk);
    bus.Req_Valid = 4'b1001;
    setData(0, 12'd3);
    setData(3, 12'd64);
    #1;
    chkVal("t6.ptrGrant", bus.Req_Ready, 4'b0001);
    @(negedge Clk);
    bus.Req_Valid = 4'b1000;
    #1;
    chkVal("t6.calcRdy", bus.Req_Ready, 0);
    @(negedge Clk);
    #1;
    chkVal("t6.rspVld", bus.Rsp_Valid, 4'b0001);
    chkVal("t6.rspDat", bus.Rsp_Data, 1);
    bus.Rsp_Ready = 4'b0001;
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    #1;
    chkVal("t6.grant3", bus.Req_Ready, 4'b1000);
    @(negedge Clk);
    bus.Req_Valid = '0;
    @(negedge Clk);
    #1;
    chkVal("t6.rsp3Vld", bus.Rsp_Valid, 4'b1000);
    chkVal("t6.rsp3Dat", bus.Rsp_Data, 6);
    bus.Rsp_Ready = 4'b1000;
    @(negedge Clk);
    bus.Rsp_Ready = '0;
    #1;
    chkVal("t6.endBusy", Busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
